// File: rtl/acorn128_ctrl_if.sv
// Handshake, stream and result signals between the ACORN-128 front end and the phase sequencer.
interface acorn128_ctrl_if;
  logic         start;
  logic [127:0] key;
  logic [127:0] iv;
  logic         ad_empty;
  logic         msg_empty;
  logic         ad_valid;
  logic         ad_bit;
  logic         ad_last;
  logic         ad_ready;
  logic         m_valid;
  logic         m_bit;
  logic         m_last;
  logic         m_ready;
  logic         ks_in;
  logic         step_out;
  logic         ca_out;
  logic         cb_out;
  logic         mbit_out;
  logic         ct_bit;
  logic         ct_valid;
  logic [127:0] tag_out;
  logic         tag_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, key, iv, ad_empty, msg_empty,
    output ad_valid, ad_bit, ad_last, m_valid, m_bit, m_last, ks_in,
    input  ad_ready, m_ready, step_out, ca_out, cb_out, mbit_out,
    input  ct_bit, ct_valid, tag_out, tag_valid, busy, done
  );

  modport slave (
    input  start, key, iv, ad_empty, msg_empty,
    input  ad_valid, ad_bit, ad_last, m_valid, m_bit, m_last, ks_in,
    output ad_ready, m_ready, step_out, ca_out, cb_out, mbit_out,
    output ct_bit, ct_valid, tag_out, tag_valid, busy, done
  );
endinterface

// File: rtl/acorn128_ctrl.sv
// ACORN-128 phase sequencer: drives per-step ca/cb/mbit controls through init, AD, padding,
// encryption and finalization, forms ciphertext bits and collects the 128-bit tag.
module acorn128_ctrl (
  input  logic           clk,
  input  logic           rst,
  acorn128_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_AD, S_AD_PAD, S_ENC, S_ENC_PAD, S_FIN, S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [10:0]  cnt_q, cnt_d;
  logic [127:0] key_q, iv_q, tag_q;
  logic         ad_empty_q, msg_empty_q, tag_valid_q;
  logic         step, ca, cb, mbit, ad_rdy, m_rdy, ct_v, ct_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    ca      = 1'b0;
    cb      = 1'b0;
    mbit    = 1'b0;
    ad_rdy  = 1'b0;
    m_rdy   = 1'b0;
    ct_v    = 1'b0;
    ct_b    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      S_INIT: begin
        step = 1'b1;
        ca   = 1'b1;
        cb   = 1'b1;
        // cnt 128..255 selects iv; every other count folds onto key[cnt mod 128]
        if (cnt_q[10:7] == 4'd1) mbit = iv_q[cnt_q[6:0]];
        else                     mbit = key_q[cnt_q[6:0]] ^ (cnt_q == 11'd256);
        cnt_d = cnt_q + 11'd1;
        if (cnt_q == 11'd1791) begin
          cnt_d   = '0;
          state_d = ad_empty_q ? S_AD_PAD : S_AD;
        end
      end
      S_AD: begin
        ad_rdy = 1'b1;
        step   = bus.ad_valid;
        ca     = 1'b1;
        cb     = 1'b1;
        mbit   = bus.ad_bit;
        if (bus.ad_valid && bus.ad_last) begin
          cnt_d   = '0;
          state_d = S_AD_PAD;
        end
      end
      S_AD_PAD, S_ENC_PAD: begin
        step  = 1'b1;
        ca    = (cnt_q[10:7] == 4'd0);
        cb    = (state_q == S_AD_PAD);
        mbit  = (cnt_q == 11'd0);
        cnt_d = cnt_q + 11'd1;
        if (cnt_q == 11'd255) begin
          cnt_d = '0;
          if (state_q == S_ENC_PAD) state_d = S_FIN;
          else                      state_d = msg_empty_q ? S_ENC_PAD : S_ENC;
        end
      end
      S_ENC: begin
        m_rdy = 1'b1;
        step  = bus.m_valid;
        ca    = 1'b1;
        mbit  = bus.m_bit;
        ct_v  = bus.m_valid;
        ct_b  = bus.m_valid & (bus.m_bit ^ bus.ks_in);
        if (bus.m_valid && bus.m_last) begin
          cnt_d   = '0;
          state_d = S_ENC_PAD;
        end
      end
      S_FIN: begin
        step  = 1'b1;
        ca    = 1'b1;
        cb    = 1'b1;
        cnt_d = cnt_q + 11'd1;
        if (cnt_q == 11'd767) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      key_q       <= '0;
      iv_q        <= '0;
      ad_empty_q  <= 1'b0;
      msg_empty_q <= 1'b0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && bus.start) begin
        key_q       <= bus.key;
        iv_q        <= bus.iv;
        ad_empty_q  <= bus.ad_empty;
        msg_empty_q <= bus.msg_empty;
        tag_q       <= '0;
        tag_valid_q <= 1'b0;
      end
      // 640 is a multiple of 128, so the low cnt bits index the tag directly
      if (state_q == S_FIN && cnt_q >= 11'd640) tag_q[cnt_q[6:0]] <= bus.ks_in;
      if (state_q == S_FIN && cnt_q == 11'd767) tag_valid_q <= 1'b1;
    end
  end

  assign bus.step_out  = step;
  assign bus.ca_out    = ca;
  assign bus.cb_out    = cb;
  assign bus.mbit_out  = mbit;
  assign bus.ad_ready  = ad_rdy;
  assign bus.m_ready   = m_rdy;
  assign bus.ct_valid  = ct_v;
  assign bus.ct_bit    = ct_b;
  assign bus.tag_out   = tag_q;
  assign bus.tag_valid = tag_valid_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: doc/acorn128_ctrl.md
# acorn128_ctrl

Phase sequencer for the ACORN-128 bit-serial datapath. It drives the per-step controls (step strobe, ca, cb, message bit) into the 293-bit state-update stage through its fixed phases: initialization, associated data (AD), AD padding, encryption, encryption padding and finalization. It also forms ciphertext bits from the datapath keystream bit and collects the 128-bit tag. It sits between the bus/stream front end and the state-update/keystream datapath, one state step per strobed cycle.

## Interface
- No parameters; all lengths are fixed by the ACORN-128 algorithm.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a new operation; honoured only in IDLE.
- key  in  128  key; latched on an accepted start.
- iv  in  128  nonce; latched on an accepted start.
- ad_empty  in  1  sampled with start; 1 = no AD bits (AD phase skipped).
- msg_empty  in  1  sampled with start; 1 = no plaintext bits (ENC phase skipped).
- ad_valid / ad_bit / ad_last  in  1 each  AD bit stream; ad_last marks the final bit.
- ad_ready  out  1  high in AD phase.
- m_valid / m_bit / m_last  in  1 each  plaintext bit stream.
- m_ready  out  1  high in ENC phase.
- ks_in  in  1  keystream bit computed by the datapath from the current state.
- step_out  out  1  datapath advances one step this cycle.
- ca_out, cb_out, mbit_out  out  1 each  step controls, valid when step_out=1.
- ct_bit, ct_valid  out  1 each  ciphertext bit = m_bit ^ ks_in, valid on ENC steps.
- tag_out  out  128  tag, held until the next accepted start or reset.
- tag_valid  out  1  high from done until the next accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion.

## Operation
- FSM states: IDLE, INIT, AD, AD_PAD, ENC, ENC_PAD, FIN, DONE. A single 11-bit step counter `cnt` resets to 0 on every phase entry.
- IDLE → INIT on start. The same edge latches key, iv, ad_empty and msg_empty, clears tag_out and tag_valid, and loads the datapath state with zero.
- **INIT:** 1792 steps, one per cycle, with ca=cb=1. mbit follows `cnt`:
  - cnt<128: key[cnt]
  - 128≤cnt<256: iv[cnt−128]
  - cnt==256: key[0]^1
  - otherwise: key[cnt mod 128]
- After INIT, go to AD, or to AD_PAD if ad_empty.
- **AD:** step_out = ad_valid (ad_ready=1). mbit=ad_bit, ca=cb=1. `cnt` is unused. A stepped bit with ad_last=1 → AD_PAD. No stall limit.
- **AD_PAD:** 256 steps with cb=1. mbit=1 at cnt==0, else 0. ca=1 for cnt<128, else 0. Then go to ENC, or to ENC_PAD if msg_empty.
- **ENC:** step_out = m_valid, mbit=m_bit, ca=1, cb=0. ct_valid=step_out. A stepped bit with m_last=1 → ENC_PAD.
- **ENC_PAD:** identical to AD_PAD except cb=0. Then → FIN.
- **FIN:** 768 steps with ca=cb=1, mbit=0. On steps cnt≥640, tag_out[cnt−640] ← ks_in. Tag bit 0 is the first of the last 128 keystream bits.
- **DONE:** one cycle with done=1 and tag_valid set; then → IDLE.
- start in any state other than IDLE is ignored.
- Control outputs are a combinational decode of the FSM state, `cnt` and the stream inputs, because streams may stall. All other outputs are registered.

## Timing
- Reset: FSM=IDLE, cnt=0, tag_out=0, and every 1-bit output = 0.
- Reset mid-operation aborts immediately. The latched key/iv are discarded, and a fresh start is required.
- start accepted at edge t: INIT steps occupy cycles t+1 … t+1792 (step_out continuously high).
- Fixed phases (INIT, AD_PAD, ENC_PAD, FIN) never deassert step_out.
- Streamed phases step only on valid&&ready. ready stays high while waiting; there is no timeout.
- ad_last/m_last are ignored unless ad_valid/m_valid is high in the same cycle.
- Phase transitions are back-to-back: the first step of the next phase is the cycle after the last step of the current one.
- Zero-length case (ad_empty=msg_empty=1): 3072 consecutive step cycles, t+1 … t+3072. done is high at t+3073 and busy is low at t+3074.
- Ciphertext latency 0: ct_bit is valid in the same cycle as the stepped m_bit.
- Tag latency: tag_out is final on the cycle done is high.

## Test plan
- **Reset:** assert rst mid-INIT (cnt≈500). Required: all outputs 0 immediately, FSM=IDLE; a new start then runs 1792 INIT steps.
- **Zero-length run:** start with ad_empty=msg_empty=1. Required: step_out high for exactly 3072 cycles and done at t+3073. The ca pattern per phase is 1792×1, then 128×1 + 128×0, then 128×1 + 128×0, then 768×1.
- **INIT mbit sequence:** key=0x0123…EF, iv=0xFEDC…10. Check mbit against key/iv for cnt 0, 127, 128, 255, 256 (key[0]^1), 257 and 1791.
- **Streamed AD with stalls:** 3 AD bits with ad_valid gaps of 5 cycles. Required: exactly 3 AD steps with step_out=0 during gaps, and AD_PAD begins the cycle after the ad_last bit.
- **Encryption:** 8 plaintext bits, ks_in forced to 10101010. Required: ct_bit = m_bit ^ ks_in on each ct_valid cycle, and cb_out=0 through ENC and ENC_PAD.
- **Tag capture and busy-start:** drive ks_in=1 only on FIN step 640, and pulse start mid-FIN. Required: tag_out=0x…0001 at done, and the mid-FIN start is ignored.
